negq_bank_write_arbiter: RTL and testbench

//   Shares one bank of negative-edge-capture storage (DEPTH x WIDTH, built from

---
 rtl/negq_bank_pkg.sv | 36 +++
 rtl/negq_rr_arbiter.sv | 26 ++
 rtl/negq_bank_write_arbiter.sv | 150 +++++++++++++++
 tb/tb_negq_bank_write_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/negq_bank_pkg.sv
// Shared definitions for the negative-edge storage write arbiter.
//   - state_t  : arbiter FSM states
//   - defaults : parameter defaults used by the top module
//   - rr_pick  : round-robin pick, returns a one-hot winner (up to MAX_NREQ requesters)
package negq_bank_pkg;

   localparam int MAX_NREQ  = 8;
   localparam int NREQ_DEF  = 4;
   localparam int WIDTH_DEF = 8;
   localparam int DEPTH_DEF = 16;
   localparam int AW_DEF    = 4;
   localparam int GAP_DEF   = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_ACK   = 2'd2,
      ST_COOL  = 2'd3
   } state_t;

   // First set request at or after ptr, wrapping modulo n. Bits at or above n
   // are never selected, so callers may zero-extend narrower request vectors.
   function automatic logic [MAX_NREQ-1:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                                   input int unsigned         ptr,
                                                   input int unsigned         n);
      logic [MAX_NREQ-1:0] win;
      logic [2:0]          idx;
      win = '0;
      for (int unsigned i = 0; i < MAX_NREQ; i++) begin
         idx = 3'((ptr + i) % n);
         if (i < n && win == '0 && req[idx]) win[idx] = 1'b1;
      end
      return win;
   endfunction

endpackage

// File: rtl/negq_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : per-requester request vector
//   ptr    : highest-priority requester index
//   winner : one-hot winner, all zero when no request
module negq_rr_arbiter
   import negq_bank_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] winner
);

   logic [MAX_NREQ-1:0] req_ext;

   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      req_ext             = '0;
      req_ext[NREQ-1:0]   = req;
      winner              = NREQ'(rr_pick(req_ext, 32'(ptr), 32'(NREQ)));
   end

endmodule

// File: rtl/negq_bank_write_arbiter.sv
// Round-robin write arbiter in front of a falling-edge storage bank.
// A granted requester's address/data are latched in IDLE, the word is written
// on the CLK falling edge inside the GRANT cycle, ACK follows one cycle later,
// then GAP_CYC cooling cycles keep the falling-edge flops within their limits.
//   CLK   : clock (control on rise, storage on fall)
//   RST   : synchronous active-high reset
//   REQ   : per-requester level request
//   ADDR  : per-requester word address, slice i = requester i
//   WDATA : per-requester write data, slice i = requester i
//   GNT   : registered one-hot grant
//   ACK   : registered one-cycle completion pulse
//   ERR   : with ACK, 1 = address out of range, nothing written
//   BUSY  : FSM not in IDLE
//   RADDR : read address
//   RDATA : combinational read, 0 for out-of-range addresses
module negq_bank_write_arbiter
   import negq_bank_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int WIDTH   = WIDTH_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int AW      = AW_DEF,
   parameter int GAP_CYC = GAP_DEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [NREQ-1:0]       REQ,
   input  logic [NREQ*AW-1:0]    ADDR,
   input  logic [NREQ*WIDTH-1:0] WDATA,
   output logic [NREQ-1:0]       GNT,
   output logic [NREQ-1:0]       ACK,
   output logic                  ERR,
   output logic                  BUSY,
   input  logic [AW-1:0]         RADDR,
   output logic [WIDTH-1:0]      RDATA
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t            state, state_nxt;
   logic [PW-1:0]     rr_ptr, win_idx, ptr_nxt;
   logic [NREQ-1:0]   win, winner_q;
   logic [NREQ-1:0]   gnt_d, ack_d;
   logic              err_d;
   logic [AW-1:0]     sel_addr, addr_q;
   logic [WIDTH-1:0]  sel_data, data_q;
   logic              oor_q;
   logic [2:0]        gap_cnt;
   logic              take, we;
   logic [WIDTH-1:0]  mem [DEPTH];

   negq_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
      .req    (REQ),
      .ptr    (rr_ptr),
      .winner (win)
   );

   assign take = (state == ST_IDLE) && (|REQ);

   // Winner index and its address/data slices.
   always_comb begin
      win_idx  = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win[i]) begin
            win_idx  = PW'(i);
            sel_addr = ADDR[i*AW +: AW];
            sel_data = WDATA[i*WIDTH +: WIDTH];
         end
      end
      ptr_nxt = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
   end

   // State register and control state.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= ST_IDLE;
         rr_ptr   <= '0;
         winner_q <= '0;
         oor_q    <= 1'b0;
         gap_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (take) begin
            winner_q <= win;
            oor_q    <= (32'(sel_addr) >= DEPTH);
            rr_ptr   <= ptr_nxt;
         end
         if (state == ST_ACK)       gap_cnt <= 3'(GAP_CYC - 1);
         else if (state == ST_COOL) gap_cnt <= gap_cnt - 1'b1;
      end
   end

   // Latched write payload; pure datapath, only meaningful after a grant.
   always_ff @(posedge CLK) begin
      if (take) begin
         addr_q <= sel_addr;
         data_q <= sel_data;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (|REQ) state_nxt = ST_GRANT;
         ST_GRANT: state_nxt = ST_ACK;
         ST_ACK:   state_nxt = (GAP_CYC > 0) ? ST_COOL : ST_IDLE;
         ST_COOL:  if (gap_cnt == '0) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Output decode: values the output registers take at the next edge.
   always_comb begin
      gnt_d = take ? win : '0;
      ack_d = (state == ST_GRANT) ? winner_q : '0;
      err_d = (state == ST_GRANT) && oor_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         GNT <= '0;
         ACK <= '0;
         ERR <= 1'b0;
      end else begin
         GNT <= gnt_d;
         ACK <= ack_d;
         ERR <= err_d;
      end
   end

   assign BUSY = (state != ST_IDLE);

   // RST is sampled combinationally so a reset raised during GRANT blocks the
   // falling-edge write before it happens.
   assign we = (state == ST_GRANT) && !oor_q && !RST;

   // NOTE: the storage array is deliberately not reset; it keeps its contents
   // across RST and a reset port would turn it into per-bit reset flops.
   always_ff @(negedge CLK) begin
      if (we) mem[addr_q] <= data_q;
   end

   assign RDATA = (32'(RADDR) < DEPTH) ? mem[RADDR] : '0;

endmodule

// File: tb/tb_negq_bank_write_arbiter.sv
// Directed bench for negq_bank_write_arbiter (NREQ=4, WIDTH=8, DEPTH=12, GAP_CYC=1).
module tb_negq_bank_write_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int DEPTH = 12;
   localparam int AW    = 4;
   localparam int GAP   = 1;

   logic                  CLK = 1'b0;
   logic                  RST;
   logic [NREQ-1:0]       REQ;
   logic [NREQ*AW-1:0]    ADDR;
   logic [NREQ*WIDTH-1:0] WDATA;
   logic [NREQ-1:0]       GNT;
   logic [NREQ-1:0]       ACK;
   logic                  ERR;
   logic                  BUSY;
   logic [AW-1:0]         RADDR;
   logic [WIDTH-1:0]      RDATA;

   int n_checks = 0;
   int n_pass   = 0;

   negq_bank_write_arbiter #(
      .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .GAP_CYC(GAP)
   ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .REQ   (REQ),
      .ADDR  (ADDR),
      .WDATA (WDATA),
      .GNT   (GNT),
      .ACK   (ACK),
      .ERR   (ERR),
      .BUSY  (BUSY),
      .RADDR (RADDR),
      .RDATA (RDATA)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_port(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      ADDR[i*AW +: AW]        = a;
      WDATA[i*WIDTH +: WIDTH] = d;
   endtask

   task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [WIDTH-1:0] exp);
      RADDR = a;
      #1;
      check(tag, 32'(RDATA), 32'(exp));
   endtask

   initial begin
      RST   = 1'b1;
      REQ   = '0;
      ADDR  = '0;
      WDATA = '0;
      RADDR = '0;

      // Reset state
      tick(); tick();
      check("rst_gnt",  32'(GNT),  32'h0);
      check("rst_ack",  32'(ACK),  32'h0);
      check("rst_err",  32'(ERR),  32'h0);
      check("rst_busy", 32'(BUSY), 32'h0);
      RST = 1'b0;

      // T1: single write from requester 2
      set_port(2, 4'd5, 8'hA5);
      REQ = 4'b0100;
      tick();
      check("t1_gnt",  32'(GNT),  32'h4);
      check("t1_busy", 32'(BUSY), 32'h1);
      check("t1_ack_early", 32'(ACK), 32'h0);
      tick();
      check("t1_ack",     32'(ACK), 32'h4);
      check("t1_err",     32'(ERR), 32'h0);
      check("t1_gnt_clr", 32'(GNT), 32'h0);
      REQ = '0;
      tick();
      check("t1_ack_pulse", 32'(ACK), 32'h0);
      read_check("t1_rdata", 4'd5, 8'hA5);
      tick();

      // T2: round robin from a fresh pointer, all requesters held high
      RST = 1'b1;
      tick();
      RST = 1'b0;
      for (int i = 0; i < NREQ; i++) set_port(i, AW'(8 + i), WIDTH'(8'h10 + i));
      REQ = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("t2_gnt%0d", k), 32'(GNT), 32'(1 << (k % 4)));
         tick();
         check($sformatf("t2_ack%0d", k), 32'(ACK), 32'(1 << (k % 4)));
         tick();
         check($sformatf("t2_cool%0d", k), 32'(GNT), 32'h0);
         tick();
         check($sformatf("t2_idle%0d", k), 32'(GNT), 32'h0);
      end
      REQ = '0;
      read_check("t2_rd9", 4'd9, 8'h11);
      read_check("t2_rd11", 4'd11, 8'h13);

      // T3: out-of-range address (pointer is at 1; only requester 0 asks)
      set_port(0, 4'd13, 8'h77);
      REQ = 4'b0001;
      tick();
      check("t3_gnt", 32'(GNT), 32'h1);
      tick();
      check("t3_ack", 32'(ACK), 32'h1);
      check("t3_err", 32'(ERR), 32'h1);
      REQ = '0;
      tick();
      check("t3_err_pulse", 32'(ERR), 32'h0);
      read_check("t3_rd13", 4'd13, 8'h00);
      read_check("t3_rd5_kept", 4'd5, 8'hA5);
      tick();

      // T4: pre-load word 3, then reset during the GRANT of an overwrite
      set_port(1, 4'd3, 8'h11);
      REQ = 4'b0010;
      tick();
      check("t4_pre_gnt", 32'(GNT), 32'h2);
      tick();
      REQ = '0;
      tick(); tick();
      read_check("t4_preload", 4'd3, 8'h11);
      set_port(2, 4'd3, 8'hFF);
      REQ = 4'b0100;
      tick();
      check("t4_gnt", 32'(GNT), 32'h4);
      RST = 1'b1;
      REQ = '0;
      tick();
      RST = 1'b0;
      check("t4_gnt_after", 32'(GNT),  32'h0);
      check("t4_busy_after", 32'(BUSY), 32'h0);
      check("t4_no_ack", 32'(ACK), 32'h0);
      tick();
      check("t4_no_ack2", 32'(ACK), 32'h0);
      read_check("t4_word_kept", 4'd3, 8'h11);

      // T5: withdrawn pulse during GRANT, new request during COOL
      set_port(0, 4'd2, 8'h22);
      REQ = 4'b0001;
      tick();
      check("t5_gnt0", 32'(GNT), 32'h1);
      REQ = 4'b0011;
      tick();
      check("t5_ack0", 32'(ACK), 32'h1);
      REQ = '0;
      tick();
      set_port(2, 4'd4, 8'h44);
      REQ = 4'b0100;
      tick();
      check("t5_cool_holdoff", 32'(GNT), 32'h0);
      tick();
      check("t5_gnt2", 32'(GNT), 32'h4);
      tick();
      check("t5_ack2", 32'(ACK), 32'h4);
      REQ = '0;
      tick(); tick();
      read_check("t5_rd4", 4'd4, 8'h44);

      // T6: read of the word being written (pointer at 3)
      set_port(3, 4'd7, 8'h5A);
      REQ = 4'b1000;
      tick();
      check("t6_pre_gnt", 32'(GNT), 32'h8);
      tick();
      REQ = '0;
      tick(); tick();
      set_port(0, 4'd7, 8'h3C);
      RADDR = 4'd7;
      REQ = 4'b0001;
      tick();
      check("t6_gnt", 32'(GNT), 32'h1);
      check("t6_before_fall", 32'(RDATA), 32'h5A);
      #5;
      check("t6_after_fall", 32'(RDATA), 32'h3C);
      tick();
      check("t6_next_rise", 32'(RDATA), 32'h3C);
      REQ = '0;
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
